// File: rtl/gray_ptr_sync.sv
// Purpose: synchronise a foreign-domain Gray pointer, decode to binary, report steps and oversize jumps.
// Latency: input stable before edge t -> upd_o/bin_o valid in the cycle after edge t+SYNC_STAGES.
// Backpressure: none; every observed pointer change produces one update pulse.
module gray_ptr_sync #(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_STEP    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] gray_i,
  input  logic         clr_i,
  output logic [W-1:0] bin_o,
  output logic         upd_o,
  output logic [W-1:0] delta_o,
  output logic         err_o,
  output logic         primed_o
);

  typedef enum logic [1:0] {
    ST_PRIME = 2'd0,
    ST_RUN   = 2'd1,
    ST_ERR   = 2'd2
  } state_t;

  // Priming loads on the edge after the chain has been refilled end to end.
  localparam logic [2:0]   CNT_LAST = 3'(SYNC_STAGES);
  localparam logic [W-1:0] MAX_W    = W'(MAX_STEP);

  logic [W-1:0] r_sync [SYNC_STAGES];
  logic [W-1:0] r_g_prev;
  logic [W-1:0] r_bin;
  logic [W-1:0] r_delta;
  logic         r_upd;
  logic         r_err;
  logic         r_primed;
  logic [2:0]   r_cnt;
  state_t       r_state;

  logic [W-1:0] w_gs;
  logic [W-1:0] w_bin;
  logic [W-1:0] w_delta_new;
  logic         w_changed;
  state_t       w_state_nxt;
  logic [2:0]   w_cnt_nxt;
  logic         w_prime_load;
  logic         w_track;
  logic         w_set_err;

  // Synchroniser chain: only the first stage ever looks at the foreign pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= gray_i;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_gs = r_sync[SYNC_STAGES-1];

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  for (genvar i = 0; i < W; i++) begin : g_dec
    assign w_bin[i] = ^w_gs[W-1:i];
  end

  assign w_delta_new = w_bin - r_bin;
  assign w_changed   = (w_gs != r_g_prev);

  // Next-state and datapath strobes; clear overrides any same-cycle update.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_prime_load = 1'b0;
    w_track      = 1'b0;
    w_set_err    = 1'b0;
    if (clr_i) begin
      w_state_nxt = ST_PRIME;
      w_cnt_nxt   = 3'd0;
    end else begin
      case (r_state)
        ST_PRIME: begin
          if (r_cnt == CNT_LAST) begin
            w_prime_load = 1'b1;
            w_state_nxt  = ST_RUN;
          end else begin
            w_cnt_nxt = r_cnt + 3'd1;
          end
        end
        ST_RUN, ST_ERR: begin
          if (w_changed) begin
            w_track = 1'b1;
            if (w_delta_new > MAX_W) begin
              w_set_err   = 1'b1;
              w_state_nxt = ST_ERR;
            end
          end
        end
        default: begin
          w_state_nxt = ST_PRIME;
          w_cnt_nxt   = 3'd0;
        end
      endcase
    end
  end

  // State register and prime counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_PRIME;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Registered outputs; bin/delta deliberately hold across a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_g_prev <= '0;
      r_bin    <= '0;
      r_delta  <= '0;
      r_upd    <= 1'b0;
      r_err    <= 1'b0;
      r_primed <= 1'b0;
    end else begin
      r_upd <= w_track;
      if (clr_i) begin
        r_err    <= 1'b0;
        r_primed <= 1'b0;
      end else begin
        if (w_prime_load) begin
          r_bin    <= w_bin;
          r_g_prev <= w_gs;
          r_delta  <= '0;
          r_primed <= 1'b1;
        end
        if (w_track) begin
          r_bin    <= w_bin;
          r_g_prev <= w_gs;
          r_delta  <= w_delta_new;
        end
        if (w_set_err) r_err <= 1'b1;
      end
    end
  end

  assign bin_o    = r_bin;
  assign upd_o    = r_upd;
  assign delta_o  = r_delta;
  assign err_o    = r_err;
  assign primed_o = r_primed;

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Directed bench for gray_ptr_sync with SYNC_STAGES=2, MAX_STEP=4, W=8.
// Inputs change 1ns after a rising edge; outputs are sampled at that same point.
module tb_gray_ptr_sync;

  logic       clk;
  logic       rst_n;
  logic [7:0] gray_i;
  logic       clr_i;
  logic [7:0] bin_o;
  logic       upd_o;
  logic [7:0] delta_o;
  logic       err_o;
  logic       primed_o;

  int vec  = 0;
  int errs = 0;
  int upd_seen = 0;
  int snap;

  gray_ptr_sync #(.W(8), .SYNC_STAGES(2), .MAX_STEP(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .gray_i   (gray_i),
    .clr_i    (clr_i),
    .bin_o    (bin_o),
    .upd_o    (upd_o),
    .delta_o  (delta_o),
    .err_o    (err_o),
    .primed_o (primed_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every update pulse seen mid-cycle.
  always @(negedge clk) if (upd_o === 1'b1) upd_seen++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Change gray_i and check the update lands exactly SYNC_STAGES edges later.
  task automatic step_check(input logic [7:0] g, input logic [7:0] eb,
                            input logic [7:0] ed, input logic ee, input string nm);
    gray_i = g;
    tick();
    tick();
    vec++; if (upd_o !== 1'b0) begin errs++; $display("FAIL %s early_upd got %b want 0", nm, upd_o); end
    tick();
    vec++; if (upd_o !== 1'b1) begin errs++; $display("FAIL %s upd got %b want 1", nm, upd_o); end
    vec++; if (bin_o !== eb) begin errs++; $display("FAIL %s bin got %h want %h", nm, bin_o, eb); end
    vec++; if (delta_o !== ed) begin errs++; $display("FAIL %s delta got %h want %h", nm, delta_o, ed); end
    vec++; if (err_o !== ee) begin errs++; $display("FAIL %s err got %b want %b", nm, err_o, ee); end
    tick();
    vec++; if (upd_o !== 1'b0) begin errs++; $display("FAIL %s upd_len got %b want 0", nm, upd_o); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; gray_i = 8'h00; clr_i = 1'b0;
    tick(); tick();
    vec++; if ({bin_o, delta_o, upd_o, err_o, primed_o} !== 19'd0) begin
      errs++; $display("FAIL reset outs got %h/%h/%b/%b/%b want all 0", bin_o, delta_o, upd_o, err_o, primed_o);
    end
    rst_n = 1'b1;
    snap = upd_seen;
    tick(); tick();
    vec++; if (primed_o !== 1'b0) begin errs++; $display("FAIL reset early_primed got %b want 0", primed_o); end
    tick();
    vec++; if (primed_o !== 1'b1) begin errs++; $display("FAIL reset primed got %b want 1", primed_o); end
    vec++; if (bin_o !== 8'h00) begin errs++; $display("FAIL reset bin got %h want 00", bin_o); end
    tick(); tick();
    vec++; if (upd_seen !== snap) begin errs++; $display("FAIL reset no_upd got %0d want %0d", upd_seen, snap); end
  endtask

  task automatic test_single_steps();
    step_check(8'h01, 8'h01, 8'h01, 1'b0, "step1");
    tick();
    step_check(8'h03, 8'h02, 8'h01, 1'b0, "step2");
  endtask

  task automatic test_multi_step();
    tick();
    step_check(8'h07, 8'h05, 8'h03, 1'b0, "jump3");
  endtask

  task automatic test_wrap();
    // Re-prime at 0xFF so the wrap step is legal.
    gray_i = 8'h80; clr_i = 1'b1;
    snap = upd_seen;
    tick();
    clr_i = 1'b0;
    vec++; if (primed_o !== 1'b0) begin errs++; $display("FAIL wrap clr_primed got %b want 0", primed_o); end
    tick(); tick(); tick();
    vec++; if (primed_o !== 1'b1) begin errs++; $display("FAIL wrap reprimed got %b want 1", primed_o); end
    vec++; if (bin_o !== 8'hFF) begin errs++; $display("FAIL wrap prime_bin got %h want ff", bin_o); end
    vec++; if (delta_o !== 8'h00) begin errs++; $display("FAIL wrap prime_delta got %h want 00", delta_o); end
    vec++; if (upd_seen !== snap) begin errs++; $display("FAIL wrap prime_upd got %0d want %0d", upd_seen, snap); end
    step_check(8'h00, 8'h00, 8'h01, 1'b0, "wrap");
  endtask

  task automatic test_error_and_clear();
    step_check(8'h07, 8'h05, 8'h05, 1'b1, "err_set");
    tick();
    step_check(8'h06, 8'h04, 8'hFF, 1'b1, "err_track");
    tick();
    step_check(8'h07, 8'h05, 8'h01, 1'b1, "err_sticky");
    clr_i = 1'b1;
    snap = upd_seen;
    tick();
    clr_i = 1'b0;
    vec++; if (err_o !== 1'b0) begin errs++; $display("FAIL clr err got %b want 0", err_o); end
    vec++; if (primed_o !== 1'b0) begin errs++; $display("FAIL clr primed got %b want 0", primed_o); end
    vec++; if (bin_o !== 8'h05) begin errs++; $display("FAIL clr bin_hold got %h want 05", bin_o); end
    vec++; if (delta_o !== 8'h01) begin errs++; $display("FAIL clr delta_hold got %h want 01", delta_o); end
    tick(); tick(); tick();
    vec++; if (primed_o !== 1'b1) begin errs++; $display("FAIL clr reprimed got %b want 1", primed_o); end
    vec++; if (bin_o !== 8'h05) begin errs++; $display("FAIL clr prime_bin got %h want 05", bin_o); end
    vec++; if (err_o !== 1'b0) begin errs++; $display("FAIL clr err_after got %b want 0", err_o); end
    vec++; if (upd_seen !== snap) begin errs++; $display("FAIL clr no_upd got %0d want %0d", upd_seen, snap); end
  endtask

  task automatic test_async_reset();
    gray_i = 8'h06;
    tick();
    #2 rst_n = 1'b0;
    #1;
    vec++; if ({bin_o, delta_o, upd_o, err_o, primed_o} !== 19'd0) begin
      errs++; $display("FAIL areset outs got %h/%h/%b/%b/%b want all 0", bin_o, delta_o, upd_o, err_o, primed_o);
    end
    tick(); tick();
    rst_n = 1'b1;
    snap = upd_seen;
    tick(); tick(); tick();
    vec++; if (primed_o !== 1'b1) begin errs++; $display("FAIL areset primed got %b want 1", primed_o); end
    vec++; if (bin_o !== 8'h04) begin errs++; $display("FAIL areset bin got %h want 04", bin_o); end
    tick(); tick(); tick();
    vec++; if (upd_seen !== snap) begin errs++; $display("FAIL areset no_upd got %0d want %0d", upd_seen, snap); end
  endtask

  initial begin
    test_reset();
    test_single_steps();
    test_multi_step();
    test_wrap();
    test_error_and_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
